// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Inhibits the bus, requests to send, shifts a frame on device clocks, checks ACK.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       keyclk_in,
   input  logic       keydata_in,
   output logic       keyclk_oe,
   output logic       keydata_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout_err
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      DATA,
      ACK,
      WAITIDLE
   } state_t;

   state_t        state, state_n;
   logic [IW-1:0] inh_cnt, inh_n;
   logic [TW-1:0] to_cnt, to_n;
   logic [9:0]    shift, shift_n;
   logic [3:0]    bit_cnt, bit_n;
   logic          cur_bit, cur_n;

   logic kclk_s1, kclk_s2, kclk_d;
   logic kdat_s1, kdat_s2;
   logic fall, inh_last, tmo_hit, active;

   logic ready_c, kclk_oe_c, kdat_oe_c;
   logic done_c, ack_c, tmo_c;

   // Idle bus reads high, so synchronisers reset to 1 to avoid a fake edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kclk_s1 <= 1'b1;
         kclk_s2 <= 1'b1;
         kclk_d  <= 1'b1;
         kdat_s1 <= 1'b1;
         kdat_s2 <= 1'b1;
      end else begin
         kclk_s1 <= keyclk_in;
         kclk_s2 <= kclk_s1;
         kclk_d  <= kclk_s2;
         kdat_s1 <= keydata_in;
         kdat_s2 <= kdat_s1;
      end
   end

   assign fall     = kclk_d & ~kclk_s2;
   assign inh_last = (inh_cnt == IW'(INHIBIT_CYCLES - 1));
   assign tmo_hit  = (to_cnt == TW'(TIMEOUT_CYCLES));
   assign active   = (state == REQ) || (state == DATA) ||
                     (state == ACK) || (state == WAITIDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         inh_cnt <= '0;
         to_cnt  <= '0;
         shift   <= '0;
         bit_cnt <= '0;
         cur_bit <= 1'b1;
      end else begin
         state   <= state_n;
         inh_cnt <= inh_n;
         to_cnt  <= to_n;
         shift   <= shift_n;
         bit_cnt <= bit_n;
         cur_bit <= cur_n;
      end
   end

   always_comb begin
      state_n   = state;
      inh_n     = inh_cnt;
      to_n      = to_cnt;
      shift_n   = shift;
      bit_n     = bit_cnt;
      cur_n     = cur_bit;
      ready_c   = 1'b0;
      kclk_oe_c = 1'b0;
      kdat_oe_c = 1'b0;
      done_c    = 1'b0;
      ack_c     = 1'b0;
      tmo_c     = 1'b0;

      unique case (state)
         IDLE: begin
            ready_c = 1'b1;
            if (tx_valid) begin
               state_n = INHIBIT;
               inh_n   = '0;
               shift_n = {1'b1, ~^tx_data, tx_data};
               bit_n   = '0;
               cur_n   = 1'b1;
            end
         end
         INHIBIT: begin
            kclk_oe_c = 1'b1;
            kdat_oe_c = inh_last;
            inh_n     = inh_cnt + 1'b1;
            to_n      = '0;
            if (inh_last) state_n = REQ;
         end
         REQ: begin
            kdat_oe_c = 1'b1;
            if (fall) begin
               cur_n   = shift[0];
               shift_n = {1'b0, shift[9:1]};
               bit_n   = 4'd1;
               state_n = DATA;
            end
         end
         DATA: begin
            kdat_oe_c = ~cur_bit;
            if (fall) begin
               cur_n   = shift[0];
               shift_n = {1'b0, shift[9:1]};
               bit_n   = bit_cnt + 1'b1;
               // Edge 10 puts out the stop bit, which is a released line.
               if (bit_cnt == 4'd9) state_n = ACK;
            end
         end
         ACK: begin
            if (fall) begin
               if (kdat_s2) begin
                  ack_c   = 1'b1;
                  state_n = IDLE;
               end else begin
                  state_n = WAITIDLE;
               end
            end
         end
         WAITIDLE: begin
            if (kclk_s2 && kdat_s2) begin
               done_c  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      // Timeout overrides whatever the state logic decided this cycle.
      if (active) begin
         to_n = to_cnt + 1'b1;
         if (tmo_hit) begin
            state_n   = IDLE;
            kdat_oe_c = 1'b0;
            done_c    = 1'b0;
            ack_c     = 1'b0;
            tmo_c     = 1'b1;
         end
      end
   end

   assign tx_ready    = ready_c;
   assign busy        = ~ready_c;
   assign keyclk_oe   = kclk_oe_c;
   assign keydata_oe  = kdat_oe_c;
   assign done        = done_c;
   assign ack_err     = ack_c;
   assign timeout_err = tmo_c;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device
// model on open-drain lines.
module tb_ps2_host_tx;

   localparam int INH = 40;
   localparam int TMO = 3000;
   localparam int HP  = 25;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, keyclk_in, keydata_in;
   logic       keyclk_oe, keydata_oe, busy;
   logic       done, ack_err, timeout_err;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;

   int checks = 0;
   int failures = 0;

   int cyc = 0, inh_run = 0, inh_len = 0;
   int done_cnt = 0, ack_cnt = 0, tmo_cnt = 0, acc_cnt = 0;
   int req_cyc = 0, tmo_cyc = 0, viol = 0;
   logic tmo_dat_oe = 1'b1;
   logic kclk_prev = 1'b0;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .keyclk_in  (keyclk_in),
      .keydata_in (keydata_in),
      .keyclk_oe  (keyclk_oe),
      .keydata_oe (keydata_oe),
      .busy       (busy),
      .done       (done),
      .ack_err    (ack_err),
      .timeout_err(timeout_err)
   );

   assign keyclk_in  = ~(keyclk_oe | dev_clk_low);
   assign keydata_in = ~(keydata_oe | dev_dat_low);

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (keyclk_oe) inh_run++;
      else if (inh_run != 0) begin
         inh_len = inh_run;
         inh_run = 0;
      end
      if (kclk_prev && !keyclk_oe) req_cyc = cyc;
      kclk_prev = keyclk_oe;
      if (done) done_cnt++;
      if (ack_err) ack_cnt++;
      if (timeout_err) begin
         tmo_cnt++;
         tmo_cyc = cyc;
         tmo_dat_oe = keydata_oe;
      end
      if (tx_valid && tx_ready) acc_cnt++;
      if (tx_ready && (keyclk_oe || keydata_oe)) viol++;
      if (32'(done) + 32'(ack_err) + 32'(timeout_err) > 1) viol++;
      if (busy === tx_ready) viol++;
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic hold);
      @(posedge clk);
      #1;
      tx_valid = 1'b1;
      tx_data  = d;
      @(posedge clk);
      #1;
      if (!hold) tx_valid = 1'b0;
   endtask

   task automatic dev_frame(input logic ack_low, input int abort_at,
                            output logic [10:0] bits, output logic ok);
      int n;
      bits = '0;
      ok = 1'b1;
      n = 0;
      while (keyclk_oe !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         ok = 1'b0;
         return;
      end
      n = 0;
      while (keyclk_oe !== 1'b0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         ok = 1'b0;
         return;
      end
      repeat (10) @(negedge clk);
      bits[0] = keydata_in;
      for (int i = 1; i <= 10; i++) begin
         dev_clk_low = 1'b1;
         repeat (HP) @(negedge clk);
         if (abort_at == i) return;
         dev_clk_low = 1'b0;
         repeat (3) @(negedge clk);
         bits[i] = keydata_in;
         repeat (HP - 3) @(negedge clk);
      end
      if (ack_low) dev_dat_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HP) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HP) @(negedge clk);
      dev_dat_low = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   logic [10:0] bits;
   logic        ok;
   int          d0, a0, t0, c0, n;

   initial begin
      // T1: reset, then reset again mid-idle
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t1_kclk_oe", 32'(keyclk_oe), 0);
      chk("t1_kdat_oe", 32'(keydata_oe), 0);
      chk("t1_ready", 32'(tx_ready), 1);
      chk("t1_busy", 32'(busy), 0);
      chk("t1_pulses", {29'd0, done, ack_err, timeout_err}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // T2: 0xED with device ACK
      d0 = done_cnt;
      a0 = ack_cnt;
      send(8'hED, 1'b0);
      dev_frame(1'b1, 0, bits, ok);
      chk("t2_req", 32'(ok), 1);
      chk("t2_inhibit_len", inh_len, INH);
      chk("t2_bits", 32'(bits), 32'(11'b11111011010));
      repeat (10) @(negedge clk);
      chk("t2_done_cnt", done_cnt - d0, 1);
      chk("t2_ack_err_cnt", ack_cnt - a0, 0);
      chk("t2_ready", 32'(tx_ready), 1);

      // T3: 0x07, device leaves ACK slot high
      d0 = done_cnt;
      a0 = ack_cnt;
      send(8'h07, 1'b0);
      dev_frame(1'b0, 0, bits, ok);
      chk("t3_req", 32'(ok), 1);
      chk("t3_bits", 32'(bits), 32'(11'b10000001110));
      chk("t3_parity", 32'(bits[9]), 0);
      repeat (10) @(negedge clk);
      chk("t3_ack_err_cnt", ack_cnt - a0, 1);
      chk("t3_done_cnt", done_cnt - d0, 0);
      chk("t3_oe", {30'd0, keyclk_oe, keydata_oe}, 0);
      chk("t3_ready", 32'(tx_ready), 1);

      // T4: 0x00, device never clocks
      t0 = tmo_cnt;
      send(8'h00, 1'b0);
      n = 0;
      while (keyclk_oe !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      while (keyclk_oe !== 1'b0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      chk("t4_start_bit_oe", 32'(keydata_oe), 1);
      n = 0;
      while (tmo_cnt == t0 && n < TMO + 500) begin
         @(negedge clk);
         n++;
      end
      chk("t4_tmo_seen", 32'(tmo_cnt - t0), 1);
      chk("t4_tmo_window",
          32'((tmo_cyc - req_cyc >= TMO - 2) && (tmo_cyc - req_cyc <= TMO + 2)),
          1);
      chk("t4_kdat_oe_at_tmo", 32'(tmo_dat_oe), 0);
      repeat (3) @(negedge clk);
      chk("t4_kdat_oe", 32'(keydata_oe), 0);
      chk("t4_ready", 32'(tx_ready), 1);

      // T5: 0xFF held valid during a 0xED transfer
      d0 = done_cnt;
      c0 = acc_cnt;
      send(8'hED, 1'b1);
      tx_data = 8'hFF;
      repeat (20) @(negedge clk);
      chk("t5_no_queue", acc_cnt - c0, 1);
      dev_frame(1'b1, 0, bits, ok);
      chk("t5_req_a", 32'(ok), 1);
      chk("t5_bits_a", 32'(bits), 32'(11'b11111011010));
      n = 0;
      while (acc_cnt - c0 < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      chk("t5_accept_b", acc_cnt - c0, 2);
      dev_frame(1'b1, 0, bits, ok);
      chk("t5_req_b", 32'(ok), 1);
      chk("t5_bits_b", 32'(bits), 32'(11'b11111111110));
      chk("t5_parity_b", 32'(bits[9]), 1);
      repeat (10) @(negedge clk);
      chk("t5_done_cnt", done_cnt - d0, 2);

      // T6: reset after falling edge #5, then clean 0xF4
      send(8'hED, 1'b0);
      dev_frame(1'b1, 5, bits, ok);
      chk("t6_req", 32'(ok), 1);
      chk("t6_bit4_driven", 32'(keydata_oe), 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t6_rst_oe", {30'd0, keyclk_oe, keydata_oe}, 0);
      chk("t6_rst_ready", 32'(tx_ready), 1);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      d0 = done_cnt;
      send(8'hF4, 1'b0);
      dev_frame(1'b1, 0, bits, ok);
      chk("t6_req_b", 32'(ok), 1);
      chk("t6_bits", 32'(bits), 32'(11'b10111101000));
      repeat (10) @(negedge clk);
      chk("t6_done_cnt", done_cnt - d0, 1);
      chk("t6_ready", 32'(tx_ready), 1);

      chk("invariants", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
